// File: rtl/map_redraw_engine_pkg.sv
// Shared constants for the map redraw engine and the game-state FSM:
// game-state codes, background image indices, frame geometry and the FSM encoding.
package map_redraw_engine_pkg;

  localparam int H_RES_DEF    = 320;
  localparam int V_RES_DEF    = 240;
  localparam int COLOUR_W_DEF = 3;

  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int ADDR_W = 17;
  localparam int GS_W   = 4;

  // Game-state codes, shared with the game-state FSM
  localparam logic [GS_W-1:0] DRAW_INITIAL  = 4'd0;
  localparam logic [GS_W-1:0] WAIT_INITIAL  = 4'd1;
  localparam logic [GS_W-1:0] DRAW_BRIDGE1  = 4'd2;
  localparam logic [GS_W-1:0] WAIT_BRIDGE1  = 4'd3;
  localparam logic [GS_W-1:0] DRAW_BRIDGE2  = 4'd4;
  localparam logic [GS_W-1:0] WAIT_BRIDGE2  = 4'd5;
  localparam logic [GS_W-1:0] DRAW_BRIDGE3  = 4'd6;
  localparam logic [GS_W-1:0] WAIT_BRIDGE3  = 4'd7;
  localparam logic [GS_W-1:0] DRAW_PILLAR   = 4'd8;
  localparam logic [GS_W-1:0] WAIT_PILLAR   = 4'd9;
  localparam logic [GS_W-1:0] PILLAR_FALL   = 4'd10;
  localparam logic [GS_W-1:0] FINISHED_GAME = 4'd11;

  // Background image indices presented on rom_sel
  typedef enum logic [2:0] {
    IMG_INITIAL  = 3'd0,
    IMG_BRIDGE1  = 3'd1,
    IMG_BRIDGE2  = 3'd2,
    IMG_BRIDGE3  = 3'd3,
    IMG_PILLAR   = 3'd4,
    IMG_FINISHED = 3'd5
  } img_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } redraw_state_e;

  // Background image for a game state; unused codes fall back to the initial image
  function automatic img_sel_e state_to_image(input logic [GS_W-1:0] gs);
    img_sel_e sel;
    case (gs)
      DRAW_INITIAL, WAIT_INITIAL:             sel = IMG_INITIAL;
      DRAW_BRIDGE1, WAIT_BRIDGE1:             sel = IMG_BRIDGE1;
      DRAW_BRIDGE2, WAIT_BRIDGE2:             sel = IMG_BRIDGE2;
      DRAW_BRIDGE3, WAIT_BRIDGE3:             sel = IMG_BRIDGE3;
      DRAW_PILLAR, WAIT_PILLAR, PILLAR_FALL:  sel = IMG_PILLAR;
      FINISHED_GAME:                          sel = IMG_FINISHED;
      default:                                sel = IMG_INITIAL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/map_redraw_engine_raster_counter.sv
// Raster scan generator: walks (xc, yc) across the frame in raster order and keeps
// the linear address in step by incrementing it, so no multiplier is needed.
module raster_counter
  import map_redraw_engine_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  output logic [X_W-1:0]    xc,
  output logic [Y_W-1:0]    yc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [X_W-1:0]    xc_q, xc_d;
  logic [Y_W-1:0]    yc_q, yc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last = (xc_q == X_LAST) && (yc_q == Y_LAST);

  // Next position: clear wins, then advance; the final pixel wraps to the origin so
  // the counters never leave the frame
  always_comb begin
    xc_d   = xc_q;
    yc_d   = yc_q;
    addr_d = addr_q;
    if (clr) begin
      xc_d   = '0;
      yc_d   = '0;
      addr_d = '0;
    end else if (en) begin
      if (last) begin
        xc_d   = '0;
        yc_d   = '0;
        addr_d = '0;
      end else if (xc_q == X_LAST) begin
        xc_d   = '0;
        yc_d   = yc_q + 8'd1;
        addr_d = addr_q + 17'd1;
      end else begin
        xc_d   = xc_q + 9'd1;
        addr_d = addr_q + 17'd1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      xc_q   <= '0;
      yc_q   <= '0;
      addr_q <= '0;
    end else begin
      xc_q   <= xc_d;
      yc_q   <= yc_d;
      addr_q <= addr_d;
    end
  end

  assign xc   = xc_q;
  assign yc   = yc_q;
  assign addr = addr_q;

endmodule

// File: rtl/map_redraw_engine.sv
// Map redraw engine: on a redraw request, latches the game state, picks the background
// image and streams every frame pixel from the image ROM to the VGA plot port.
// doneRedraw stays up until the game state moves on, so the requester does not loop.
module map_redraw_engine
  import map_redraw_engine_pkg::*;
#(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawMap,
  input  logic [GS_W-1:0]     gameState,
  output logic [2:0]          rom_sel,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                doneRedraw
);

  redraw_state_e   state_q, state_d;
  logic [GS_W-1:0] st_q, st_d;
  img_sel_e        rom_sel_q, rom_sel_d;
  logic [X_W-1:0]  x_q;
  logic [Y_W-1:0]  y_q;
  logic            we_q, we_d;

  logic            cnt_clr, cnt_en, cnt_last;
  logic [X_W-1:0]  xc;
  logic [Y_W-1:0]  yc;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .xc     (xc),
    .yc     (yc),
    .addr   (rom_addr),
    .last   (cnt_last)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; drawMap is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drawMap)          state_d = ST_SWEEP;
      ST_SWEEP: if (cnt_last)         state_d = ST_FLUSH;
      ST_FLUSH:                       state_d = ST_DONE;
      ST_DONE:  if (gameState != st_q) state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control, state/image capture, address-valid and done flag
  always_comb begin
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    st_d       = st_q;
    rom_sel_d  = rom_sel_q;
    we_d       = 1'b0;
    doneRedraw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drawMap) begin
          cnt_clr   = 1'b1;
          st_d      = gameState;
          rom_sel_d = state_to_image(gameState);
        end
      end
      ST_SWEEP: begin
        cnt_en = 1'b1;
        we_d   = 1'b1;
      end
      ST_DONE:  doneRedraw = 1'b1;
      default: ;
    endcase
  end

  // Captured game state and image select, frozen for the whole sweep
  always_ff @(posedge clock) begin
    if (!resetn) begin
      st_q      <= '0;
      rom_sel_q <= IMG_INITIAL;
    end else begin
      st_q      <= st_d;
      rom_sel_q <= rom_sel_d;
    end
  end

  // Plot pipeline: coordinates and strobe delayed one cycle to meet the ROM read data
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q  <= '0;
      y_q  <= '0;
      we_q <= 1'b0;
    end else begin
      x_q  <= xc;
      y_q  <= yc;
      we_q <= we_d;
    end
  end

  assign rom_sel = rom_sel_q;
  assign x       = x_q;
  assign y       = y_q;
  assign writeEn = we_q;
  // ROM data passes straight through while plotting; held at zero otherwise so the
  // shared plot mux never sees stale pixels from this block
  assign colour  = we_q ? rom_data : '0;

endmodule

// File: tb/tb_map_redraw_engine.sv
// Bench for map_redraw_engine. Runs the engine with the full 320-pixel line width and a
// short 4-line frame so many complete sweeps fit in a small cycle count. The expected
// pixel stream, image choice and handshake behaviour come from a behavioural model.
module tb_map_redraw_engine;

  localparam int TH = 320;
  localparam int TV = 4;
  localparam int NPIX = TH * TV;

  logic        clock;
  logic        resetn;
  logic        drawMap;
  logic [3:0]  gameState;
  logic [2:0]  rom_sel;
  logic [16:0] rom_addr;
  logic [2:0]  rom_data;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        doneRedraw;

  int n_cmp = 0;
  int n_bad = 0;
  int seed  = 0;

  map_redraw_engine #(
    .H_RES    (TH),
    .V_RES    (TV),
    .COLOUR_W (3)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .drawMap    (drawMap),
    .gameState  (gameState),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .writeEn    (writeEn),
    .doneRedraw (doneRedraw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Image content: a scrambled function of image index and pixel address
  function automatic int rom_fn(input int sel, input int addr);
    int v;
    v = addr * 13 + (addr >> 4) + sel * 7 + seed;
    return v & 7;
  endfunction

  // Image ROM with one cycle of read latency
  always @(posedge clock) rom_data <= 3'(rom_fn(int'(rom_sel), int'(rom_addr)));

  // Image choice: pairs of states share an image up to 7, 8..10 pillar, 11 finished
  function automatic int exp_sel(input int gs);
    if (gs < 8)   return gs / 2;
    if (gs <= 10) return 4;
    if (gs == 11) return 5;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a sweep (drawMap must already be high, engine idle) and follows the pixel
  // stream. Optionally changes gameState after pixel change_at, or asserts reset after
  // pixel abort_at and returns early.
  task automatic sweep(input int sel, input int change_at, input int new_gs, input int abort_at);
    int  k;
    bit  stop;
    k    = 0;
    stop = 0;
    tick();
    check("start_we", writeEn, 0);
    check("start_addr", rom_addr, 0);
    check("start_sel", rom_sel, sel);
    for (int c = 0; c < NPIX + 8 && !stop; c++) begin
      tick();
      if (doneRedraw) begin
        stop = 1;
        check("pixels_before_done", k, NPIX);
        check("done_we", writeEn, 0);
        drawMap = 1'b0;
      end else if (writeEn) begin
        if (k == 0) check("first_we_latency", c, 0);
        check("x", x, k % TH);
        check("y", y, k / TH);
        check("colour", colour, rom_fn(sel, k));
        check("sweep_sel", rom_sel, sel);
        if (k < NPIX - 1) check("rom_addr", rom_addr, k + 1);
        k++;
        if (k == change_at) gameState = 4'(new_gs);
        if (k == abort_at) begin
          resetn = 1'b0;
          stop   = 1;
        end
      end else begin
        check("no_gap", writeEn, 1);
      end
    end
    if (!stop) check("done_timeout", doneRedraw, 1);
  endtask

  initial begin
    int gs;
    int pos;
    resetn    = 1'b0;
    drawMap   = 1'b0;
    gameState = 4'd0;
    seed      = int'($urandom_range(0, 1023));

    // Reset state
    repeat (3) tick();
    check("rst_we", writeEn, 0);
    check("rst_done", doneRedraw, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_sel", rom_sel, 0);
    check("rst_colour", colour, 0);
    resetn = 1'b1;
    tick();
    check("idle_we", writeEn, 0);
    check("idle_done", doneRedraw, 0);

    // Initial image, full sweep, done sticks while the state is unchanged
    drawMap = 1'b1;
    sweep(0, -1, 0, -1);
    tick();
    check("done_sticky", doneRedraw, 1);

    // Bridge2 image
    gameState = 4'd4;
    tick();
    check("done_clear_gs4", doneRedraw, 0);
    drawMap = 1'b1;
    sweep(2, -1, 0, -1);

    // drawMap pulses while done with an unchanged state are ignored
    for (int i = 0; i < 16; i++) begin
      drawMap = 1'($urandom_range(0, 1));
      tick();
      check("done_hold", doneRedraw, 1);
      check("done_hold_we", writeEn, 0);
    end
    drawMap   = 1'b0;
    gameState = 4'd5;
    tick();
    check("done_drop_gs5", doneRedraw, 0);
    repeat (2) begin
      tick();
      check("idle_after_gs5_we", writeEn, 0);
      check("idle_after_gs5_done", doneRedraw, 0);
    end

    // State change mid-sweep: image stays fixed, done only pulses, new sweep follows
    gameState = 4'd2;
    tick();
    drawMap = 1'b1;
    pos = int'($urandom_range(NPIX / 4, 3 * NPIX / 4));
    sweep(1, pos, 6, -1);
    tick();
    check("done_pulse_end", doneRedraw, 0);
    tick();
    check("idle_after_pulse_we", writeEn, 0);
    drawMap = 1'b1;
    sweep(3, -1, 0, -1);

    // Reset in the middle of a sweep, then a clean restart
    gs = int'($urandom_range(0, 9));
    if (gs == 6) gs = 10;
    gameState = 4'(gs);
    tick();
    check("done_drop_t5", doneRedraw, 0);
    drawMap = 1'b1;
    pos = int'($urandom_range(100, NPIX - 100));
    sweep(exp_sel(gs), -1, 0, pos);
    tick();
    check("abort_we", writeEn, 0);
    check("abort_done", doneRedraw, 0);
    check("abort_x", x, 0);
    check("abort_y", y, 0);
    check("abort_addr", rom_addr, 0);
    check("abort_sel", rom_sel, 0);
    resetn  = 1'b1;
    drawMap = 1'b0;
    tick();
    check("post_abort_we", writeEn, 0);
    drawMap = 1'b1;
    sweep(exp_sel(gs), -1, 0, -1);

    // Finished-game image, then an unused state code
    gameState = 4'd11;
    tick();
    check("done_drop_gs11", doneRedraw, 0);
    drawMap = 1'b1;
    sweep(5, -1, 0, -1);
    gameState = 4'd13;
    tick();
    check("done_drop_gs13", doneRedraw, 0);
    drawMap = 1'b1;
    sweep(0, -1, 0, -1);

    // Random game states
    gs = 13;
    for (int r = 0; r < 3; r++) begin
      gs = (gs + 1 + int'($urandom_range(0, 14))) % 16;
      gameState = 4'(gs);
      tick();
      check("done_drop_rand", doneRedraw, 0);
      drawMap = 1'b1;
      sweep(exp_sel(gs), -1, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
